// File: rtl/windowed_register_file_if.sv
// Bus bundle for windowed_register_file.
// Purpose: groups the read/write ports, window-control and clear-engine signals so the
//   register file and its user (integer unit or bench) connect through one port.
// Signals:
//   PA_in/PB_in    - logical read addresses (r0..r31) for ports A/B
//   PC_in, in      - logical write address and write data, qualified by enable
//   PA_out/PB_out  - combinational read data
//   save/restore   - move CWP down/up; wim_we/wim_in load the window-invalid mask
//   current_window - CWP, zero-extended to 5 bits; wim_out - current WIM
//   overflow_trap/underflow_trap/window_err - registered one-cycle pulses
//   clr_all        - start bulk clear; busy - bulk clear in progress
// Modports: master drives requests, slave is the register file.
interface windowed_register_file_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NWINDOWS = 4
);
  logic [4:0]          PA_in;
  logic [4:0]          PB_in;
  logic [4:0]          PC_in;
  logic [WIDTH-1:0]    in;
  logic                enable;
  logic [WIDTH-1:0]    PA_out;
  logic [WIDTH-1:0]    PB_out;
  logic                save;
  logic                restore;
  logic                wim_we;
  logic [NWINDOWS-1:0] wim_in;
  logic [4:0]          current_window;
  logic [NWINDOWS-1:0] wim_out;
  logic                overflow_trap;
  logic                underflow_trap;
  logic                window_err;
  logic                clr_all;
  logic                busy;

  modport master (
    output PA_in, PB_in, PC_in, in, enable, save, restore, wim_we, wim_in, clr_all,
    input  PA_out, PB_out, current_window, wim_out, overflow_trap, underflow_trap,
           window_err, busy
  );

  modport slave (
    input  PA_in, PB_in, PC_in, in, enable, save, restore, wim_we, wim_in, clr_all,
    output PA_out, PB_out, current_window, wim_out, overflow_trap, underflow_trap,
           window_err, busy
  );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC V8-style overlapping-window register file with a current window pointer (CWP),
// window-invalid mask (WIM) trap detection and a sequential clear-all engine.
// Ports:
//   Clk     - rising-edge clock
//   Reset_n - asynchronous active-low reset (clears array, CWP, WIM, traps, FSM)
//   bus_io  - windowed_register_file_if slave modport carrying all data/control signals
// Parameters: WIDTH data width; NWINDOWS window count (2..32). Physical array holds
//   8 + 16*NWINDOWS registers: 8 globals, then per window 8 outs followed by 8 locals.
//   A window's ins are the outs of the next-higher window (mod NWINDOWS).
module windowed_register_file #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NWINDOWS = 4
) (
  input logic                     Clk,
  input logic                     Reset_n,
  windowed_register_file_if.slave bus_io
);

  localparam int unsigned NRegs = 8 + 16 * NWINDOWS;
  localparam int unsigned PhysW = $clog2(NRegs);

  typedef logic [PhysW-1:0] phys_t;
  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              state_q, state_d;
  phys_t               clr_idx_q, clr_idx_d;
  logic [4:0]          cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                werr_q, werr_d;
  logic [WIDTH-1:0]    regs_q [NRegs];

  logic       busy;
  logic       wr_en;
  phys_t      wr_idx, rd_a_idx, rd_b_idx;
  logic [4:0] cwp_dec, cwp_inc;

  // Logical register r in window w -> physical index.
  function automatic phys_t map_addr(input logic [4:0] r, input logic [4:0] w);
    int unsigned ri, wi, wn, idx;
    ri = 32'(r);
    wi = 32'(w);
    wn = (wi == NWINDOWS - 1) ? 0 : wi + 1;
    if (ri < 8)       idx = ri;
    else if (ri < 16) idx = 8 + 16 * wi + (ri - 8);
    else if (ri < 24) idx = 16 + 16 * wi + (ri - 16);
    else              idx = 8 + 16 * wn + (ri - 24);
    return PhysW'(idx);
  endfunction

  // Bit w of the mask; shift keeps the index width independent of NWINDOWS.
  function automatic logic wim_bit(input logic [NWINDOWS-1:0] wim, input logic [4:0] w);
    logic [NWINDOWS-1:0] s;
    s = wim >> w;
    return s[0];
  endfunction

  always_comb begin
    busy     = (state_q == StClear);
    cwp_dec  = (cwp_q == 5'd0) ? 5'(NWINDOWS - 1) : cwp_q - 5'd1;
    cwp_inc  = (cwp_q == 5'(NWINDOWS - 1)) ? 5'd0 : cwp_q + 5'd1;
    wr_en    = bus_io.enable && (bus_io.PC_in != 5'd0) && !busy;
    wr_idx   = map_addr(bus_io.PC_in, cwp_q);
    rd_a_idx = map_addr(bus_io.PA_in, cwp_q);
    rd_b_idx = map_addr(bus_io.PB_in, cwp_q);
  end

  // Clear engine: one physical register per cycle, indices 0..NRegs-1.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.clr_all) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end
      end
      StClear: begin
        clr_idx_d = clr_idx_q + PhysW'(1);
        if (clr_idx_q == PhysW'(NRegs - 1)) begin
          state_d   = StIdle;
          clr_idx_d = '0;
        end
      end
      default: begin
        state_d   = StIdle;
        clr_idx_d = '0;
      end
    endcase
  end

  // Window control; the WIM checked here is the value before any same-cycle load.
  always_comb begin
    cwp_d  = cwp_q;
    wim_d  = wim_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    werr_d = 1'b0;
    if (!busy) begin
      if (bus_io.wim_we) wim_d = bus_io.wim_in;
      if (bus_io.save && bus_io.restore) begin
        werr_d = 1'b1;
      end else if (bus_io.save) begin
        if (wim_bit(wim_q, cwp_dec)) ovf_d = 1'b1;
        else                         cwp_d = cwp_dec;
      end else if (bus_io.restore) begin
        if (wim_bit(wim_q, cwp_inc)) unf_d = 1'b1;
        else                         cwp_d = cwp_inc;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      clr_idx_q <= '0;
      cwp_q     <= '0;
      wim_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cwp_q     <= cwp_d;
      wim_q     <= wim_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NRegs; i++) regs_q[i] <= '0;
    end else if (busy) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= bus_io.in;
    end
  end

  // No write bypass: reads see the array as it stands before the edge.
  always_comb begin
    bus_io.PA_out         = (bus_io.PA_in == 5'd0) ? '0 : regs_q[rd_a_idx];
    bus_io.PB_out         = (bus_io.PB_in == 5'd0) ? '0 : regs_q[rd_b_idx];
    bus_io.current_window = cwp_q;
    bus_io.wim_out        = wim_q;
    bus_io.overflow_trap  = ovf_q;
    bus_io.underflow_trap = unf_q;
    bus_io.window_err     = werr_q;
    bus_io.busy           = busy;
  end

endmodule

// File: tb/tb_windowed_register_file.sv
// Self-checking bench for windowed_register_file (WIDTH=32, NWINDOWS=4).
module tb_windowed_register_file;
  localparam int unsigned W = 32;
  localparam int unsigned N = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  windowed_register_file_if #(.WIDTH(W), .NWINDOWS(N)) bus ();

  windowed_register_file #(.WIDTH(W), .NWINDOWS(N)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus_io (bus)
  );

  typedef enum logic [2:0] {VWr, VRdA, VRdB, VSave, VRest, VCwp} vop_e;
  typedef struct {
    vop_e        op;
    logic [4:0]  addr;
    logic [31:0] data;  // write data, or expected value for reads/CWP checks
  } vec_t;

  vec_t vq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input vop_e op, input logic [4:0] a, input logic [31:0] d);
    vec_t v;
    v.op = op;
    v.addr = a;
    v.data = d;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.PA_in = '0; bus.PB_in = '0; bus.PC_in = '0; bus.in = '0; bus.enable = 1'b0;
    bus.save = 1'b0; bus.restore = 1'b0; bus.wim_we = 1'b0; bus.wim_in = '0;
    bus.clr_all = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.PC_in = a; bus.in = d; bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
  endtask

  task automatic do_save();
    bus.save = 1'b1;
    step();
    bus.save = 1'b0;
  endtask

  task automatic do_restore();
    bus.restore = 1'b1;
    step();
    bus.restore = 1'b0;
  endtask

  task automatic set_wim(input logic [N-1:0] v);
    bus.wim_we = 1'b1; bus.wim_in = v;
    step();
    bus.wim_we = 1'b0;
  endtask

  task automatic check_rd(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.PA_in = a;
    #1;
    check(name, bus.PA_out, exp);
  endtask

  initial begin
    int cnt;
    idle_inputs();
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    // Reset state visible while still in reset
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset wim", 32'(bus.wim_out), 32'd0);
    check("reset traps", 32'({bus.overflow_trap, bus.underflow_trap, bus.window_err}), 32'd0);
    Reset_n = 1'b1;
    step();

    // ---------------- table-driven vectors ----------------
    add(VCwp, 5'd0,  32'd0);
    add(VRdA, 5'd1,  32'd0);
    add(VWr,  5'd1,  32'd5);
    add(VWr,  5'd8,  32'h11);
    add(VWr,  5'd16, 32'h22);
    add(VWr,  5'd0,  32'hFF);
    add(VRdA, 5'd1,  32'd5);
    add(VRdB, 5'd8,  32'h11);
    add(VRdA, 5'd16, 32'h22);
    add(VRdA, 5'd0,  32'd0);
    add(VRest, 5'd0, 32'd0);    // cwp 1
    add(VCwp, 5'd0,  32'd1);
    add(VWr,  5'd8,  32'hAB);
    add(VRdB, 5'd8,  32'hAB);
    add(VSave, 5'd0, 32'd0);    // cwp 0
    add(VCwp, 5'd0,  32'd0);
    add(VRdA, 5'd24, 32'hAB);   // ins of w0 = outs of w1
    add(VRest, 5'd0, 32'd0);    // cwp 1
    add(VCwp, 5'd0,  32'd1);
    add(VRdA, 5'd8,  32'hAB);
    add(VRdB, 5'd1,  32'd5);
    add(VSave, 5'd0, 32'd0);    // cwp 0
    add(VSave, 5'd0, 32'd0);    // wraps to 3
    add(VCwp, 5'd0,  32'd3);
    add(VRdA, 5'd24, 32'h11);   // ins of w3 = outs of w0
    add(VRdB, 5'd1,  32'd5);
    add(VRest, 5'd0, 32'd0);    // wraps to 0
    add(VCwp, 5'd0,  32'd0);
    for (int w = 0; w < 4; w++) begin
      add(VWr, 5'd16, 32'(100 + w));
      add(VRest, 5'd0, 32'd0);
    end
    add(VCwp, 5'd0,  32'd0);
    for (int w = 0; w < 4; w++) begin
      add(VRdA, 5'd16, 32'(100 + w));
      add(VRest, 5'd0, 32'd0);
    end
    add(VCwp, 5'd0,  32'd0);

    foreach (vq[i]) begin
      unique case (vq[i].op)
        VWr:   do_write(vq[i].addr, vq[i].data);
        VRdA:  check_rd($sformatf("vec%0d rdA r%0d", i, vq[i].addr), vq[i].addr, vq[i].data);
        VRdB: begin
          bus.PB_in = vq[i].addr;
          #1;
          check($sformatf("vec%0d rdB r%0d", i, vq[i].addr), bus.PB_out, vq[i].data);
        end
        VSave: do_save();
        VRest: do_restore();
        VCwp:  check($sformatf("vec%0d cwp", i), 32'(bus.current_window), vq[i].data);
        default: ;
      endcase
    end

    // ---------------- no write bypass ----------------
    bus.PC_in = 5'd5; bus.in = 32'h77; bus.enable = 1'b1; bus.PA_in = 5'd5;
    #1;
    check("no bypass before edge", bus.PA_out, 32'd0);
    step();
    bus.enable = 1'b0;
    check("write lands after edge", bus.PA_out, 32'h77);

    // ---------------- traps ----------------
    set_wim(4'b1000);
    do_save();
    check("overflow pulse", 32'(bus.overflow_trap), 32'd1);
    check("overflow cwp", 32'(bus.current_window), 32'd0);
    step();
    check("overflow one cycle", 32'(bus.overflow_trap), 32'd0);
    set_wim(4'b0010);
    do_restore();
    check("underflow pulse", 32'(bus.underflow_trap), 32'd1);
    check("underflow cwp", 32'(bus.current_window), 32'd0);
    step();
    check("underflow one cycle", 32'(bus.underflow_trap), 32'd0);
    bus.save = 1'b1; bus.restore = 1'b1;
    step();
    bus.save = 1'b0; bus.restore = 1'b0;
    check("window_err pulse", 32'(bus.window_err), 32'd1);
    check("window_err cwp", 32'(bus.current_window), 32'd0);
    step();
    check("window_err one cycle", 32'(bus.window_err), 32'd0);
    // Same-cycle WIM load: save checks old WIM (0010) so it proceeds to 3
    bus.wim_we = 1'b1; bus.wim_in = 4'b1000; bus.save = 1'b1;
    step();
    bus.wim_we = 1'b0; bus.save = 1'b0;
    check("old wim save cwp", 32'(bus.current_window), 32'd3);
    check("old wim loaded", 32'(bus.wim_out), 32'h8);
    check("old wim no trap", 32'(bus.overflow_trap), 32'd0);
    do_restore();
    check("restore to 0", 32'(bus.current_window), 32'd0);
    // Write + save together: write uses old CWP
    set_wim(4'b0000);
    bus.PC_in = 5'd16; bus.in = 32'h55; bus.enable = 1'b1; bus.save = 1'b1;
    step();
    bus.enable = 1'b0; bus.save = 1'b0;
    check("write+save cwp", 32'(bus.current_window), 32'd3);
    check_rd("write+save w3 r16", 5'd16, 32'd103);
    do_restore();
    check_rd("write+save w0 r16", 5'd16, 32'h55);

    // ---------------- clear-all ----------------
    for (int r = 1; r < 8; r++) do_write(5'(r), 32'h0F00 + 32'(r));
    for (int w = 0; w < 4; w++) begin
      for (int r = 8; r < 24; r++) do_write(5'(r), 32'h1000 + 32'(w * 32 + r));
      do_restore();
    end
    do_restore();  // cwp 1
    set_wim(4'b0101);
    check_rd("fill w1 r8", 5'd8, 32'h1028);
    check_rd("fill w1 r24", 5'd24, 32'h1048);
    bus.clr_all = 1'b1;
    step();
    bus.clr_all = 1'b0;
    cnt = 0;
    while (bus.busy && cnt < 200) begin
      if (cnt == 60) begin
        bus.PC_in = 5'd1; bus.in = 32'hDEAD; bus.enable = 1'b1;
        bus.save = 1'b1; bus.wim_we = 1'b1; bus.wim_in = 4'b1111;
      end
      if (cnt == 61) check("no trap while busy", 32'(bus.overflow_trap), 32'd0);
      step();
      bus.enable = 1'b0; bus.save = 1'b0; bus.wim_we = 1'b0;
      cnt++;
    end
    check("clear busy cycles", 32'(cnt), 32'd72);
    check("clear keeps cwp", 32'(bus.current_window), 32'd1);
    check("clear keeps wim", 32'(bus.wim_out), 32'h5);
    set_wim(4'b0000);
    for (int w = 0; w < 4; w++) begin
      for (int r = 1; r < 32; r++) check_rd($sformatf("cleared w%0d r%0d", (w + 1) % 4, r), 5'(r), 32'd0);
      do_restore();
    end

    // ---------------- reset mid-clear ----------------
    do_write(5'd1, 32'd7);
    do_write(5'd20, 32'd9);  // w1 local, physical 36
    set_wim(4'b0011);
    bus.clr_all = 1'b1;
    step();
    bus.clr_all = 1'b0;
    repeat (30) step();
    check("mid-clear busy", 32'(bus.busy), 32'd1);
    check_rd("mid-clear r1 cleared", 5'd1, 32'd0);
    check_rd("mid-clear r20 live", 5'd20, 32'd9);
    #2 Reset_n = 1'b0;
    #1;
    check("reset abort busy", 32'(bus.busy), 32'd0);
    check("reset abort cwp", 32'(bus.current_window), 32'd0);
    check("reset abort wim", 32'(bus.wim_out), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    step();
    do_restore();  // cwp 1
    check_rd("reset zeroed w1 r20", 5'd20, 32'd0);
    do_write(5'd1, 32'd7);
    do_write(5'd2, 32'd3);
    bus.clr_all = 1'b1;
    step();
    bus.clr_all = 1'b0;
    step();
    step();
    cnt = 2;
    check_rd("restart cleared r1", 5'd1, 32'd0);
    check_rd("restart not yet r2", 5'd2, 32'd3);
    while (bus.busy && cnt < 200) begin
      step();
      cnt++;
    end
    check("restart busy cycles", 32'(cnt), 32'd72);
    check_rd("restart r2 cleared", 5'd2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/windowed_register_file.md
Name: windowed_register_file

Overview:
- Parametrised successor to the fixed 4-window register file.
- Implements a SPARC V8-style overlapping-window register file with configurable data width and window count, plus an internal current window pointer (CWP).
- SAVE/RESTORE move the CWP with window-invalid-mask (WIM) overflow/underflow detection.
- A sequential clear-all engine zeroes the physical array. It sits between decode and ALU in the integer unit.

Parameters:
- WIDTH, 32, data width of each register.
- NWINDOWS, 4, number of register windows; legal range 2..32, any integer. The physical array holds 8+16*NWINDOWS registers.

Ports:
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous active-low reset
- PA_in  input  5  port A read address (logical r0..r31)
- PB_in  input  5  port B read address
- PC_in  input  5  write address
- in  input  WIDTH  write data
- enable  input  1  write enable
- PA_out  output  WIDTH  port A read data
- PB_out  output  WIDTH  port B read data
- save  input  1  decrement CWP request
- restore  input  1  increment CWP request
- wim_we  input  1  WIM write enable
- wim_in  input  NWINDOWS  new WIM value
- current_window  output  5  CWP, zero-extended
- wim_out  output  NWINDOWS  current WIM
- overflow_trap  output  1  one-cycle pulse: save blocked by WIM
- underflow_trap  output  1  one-cycle pulse: restore blocked by WIM
- window_err  output  1  one-cycle pulse: save and restore both asserted
- clr_all  input  1  start bulk clear
- busy  output  1  bulk clear in progress

Behaviour:
- Reset (async, Reset_n=0): all physical registers 0, CWP=0, WIM=0, all trap pulses 0, busy=0, FSM=IDLE.
- Logical-to-physical mapping, w=CWP:
  - r0..r7 → globals 0..7.
  - r8..r15 (outs) → 8+16*w+(r-8).
  - r16..r23 (locals) → 16+16*w+(r-16).
  - r24..r31 (ins) → outs of window (w+1) mod NWINDOWS, i.e. 8+16*((w+1) mod N)+(r-24).
- Reads: combinational from PA_in/PB_in and the current CWP. r0 always reads 0. No write bypass: a same-cycle read of the register being written returns the old value until the edge.
- Writes: on the rising edge when enable=1, PC_in≠0 and busy=0. Writes to r0 are discarded. Mapping uses the CWP value before that edge.
- save=1, restore=0, busy=0:
  - If WIM[(CWP-1) mod N]=1: overflow_trap=1 next cycle, CWP unchanged.
  - Otherwise: CWP ← (CWP-1) mod N; CWP=0 wraps to N-1.
- restore=1, save=0, busy=0:
  - If WIM[(CWP+1) mod N]=1: underflow_trap=1 next cycle, CWP unchanged.
  - Otherwise: CWP ← (CWP+1) mod N; N-1 wraps to 0.
- save=restore=1: CWP unchanged, window_err=1 for one cycle.
- Trap and error outputs are registered and high for exactly one cycle per offending request. They stay 0 when no request is present.
- WIM: wim_we loads wim_in on the edge. A save/restore in the same cycle checks the old WIM.
- Write and save/restore in the same cycle: the write lands at its old-CWP physical location, then CWP moves.
- Clear FSM, IDLE → CLEAR:
  - Entry: clr_all=1 in IDLE. busy=1 from the next edge.
  - CLEAR zeroes physical index k on the edge, k=0..8+16N-1, one register per cycle, then returns to IDLE. busy is high for exactly 8+16N cycles (72 at N=4).
  - clr_all is ignored while busy.
  - While busy: writes, save, restore and wim_we are ignored, and no traps are raised. Reads return the live array (partially cleared).
  - CWP and WIM are not affected by the clear.
- Reset_n low during CLEAR aborts immediately to the full reset state.

Test Plan:
- Reset, then N=4, CWP=0: write r1=5, r8=0x11, r16=0x22 → PA_in=1 reads 5, PB_in=8 reads 0x11; PA_in=16 reads 0x22; PA_in=0 reads 0 even after writing r0=0xFF.
- Overlap: CWP=1, write r8=0xAB; save → current_window=0; read r24 → 0xAB; restore → current_window=1, r8 still 0xAB. Globals r1..r7 are identical in every window.
- Wrap: CWP=0, save → current_window=3; restore → 0. Every window's r16 holds a distinct value 100+w with no aliasing.
- Traps:
  - WIM=4'b1000, CWP=0, save → overflow_trap high one cycle, current_window stays 0.
  - WIM=4'b0010, CWP=0, restore → underflow_trap, CWP stays 0.
  - save+restore together → window_err, no CWP change.
- Clear-all: fill all 72 physical registers with nonzero data, pulse clr_all → busy high exactly 72 cycles. A write attempted mid-clear is dropped. Afterwards all registers read 0 in all windows, CWP/WIM unchanged.
- Reset mid-clear: Reset_n low at cycle 30 of CLEAR → busy=0 immediately, all reads 0, CWP=0, WIM=0; a new clr_all after release restarts from index 0.
